// File: rtl/yin_window_buffer_pkg.sv
// Shared definitions for the YIN pitch-detection chain: default widths,
// the window-length formula and the flat-frame slot indexing helper.
package yin_window_buffer_pkg;

    localparam int DATA_WIDTH_DEF       = 8;
    localparam int WINDOW_SIZE_BITS_DEF = 8;
    localparam int MAX_TAU_DEF          = 40;

    typedef enum logic {
        FILL,
        STREAM
    } state_t;

    // Total samples held per frame: integration window plus the lag tail.
    function automatic int calc_n(input int window_size_bits, input int max_tau);
        return (2 ** window_size_bits) + max_tau;
    endfunction

    // LSB position of slot k inside a flat frame bus (slot 0 = oldest).
    function automatic int slot_lsb(input int slot, input int data_width);
        return slot * data_width;
    endfunction

endpackage

// File: rtl/yin_window_buffer_shiftreg.sv
// Live sample window. Stores the N-1 most recent samples; with sample_in
// appended as the newest slot this forms the N-deep window seen this cycle.
module yin_sample_shiftreg
    import yin_window_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = calc_n(WINDOW_SIZE_BITS_DEF, MAX_TAU_DEF)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          shift_en,
    input  logic [DATA_WIDTH-1:0]         sample_in,
    output logic [DEPTH*DATA_WIDTH-1:0]   window_next
);

    logic [(DEPTH-1)*DATA_WIDTH-1:0] history;

    assign window_next = {sample_in, history};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    // NOTE: the sample store is reset too, so a reset leaves no stale samples
    // that could leak into a later frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history <= '0;
        end else if (shift_en) begin
            history <= window_next[DEPTH*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

endmodule

// File: rtl/yin_window_buffer.sv
// Sample capture front end: maintains the sliding window and publishes a
// frozen snapshot every HOP samples once the first N samples have arrived.
module yin_window_buffer
    import yin_window_buffer_pkg::*;
#(
    parameter int  DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int  WINDOW_SIZE_BITS = WINDOW_SIZE_BITS_DEF,
    parameter int  MAX_TAU          = MAX_TAU_DEF,
    parameter int  HOP              = 64,
    localparam int N                = calc_n(WINDOW_SIZE_BITS, MAX_TAU),
    localparam int CW               = $clog2(N + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     sample_in,
    input  logic                      sample_valid,
    output logic [N*DATA_WIDTH-1:0]   frame,
    output logic                      frame_valid,
    input  logic                      frame_ack,
    output logic [7:0]                frames_dropped,
    output logic                      filling
);

    state_t                  state, state_next;
    logic [CW-1:0]           count, count_next;
    logic                    snap;
    logic [N*DATA_WIDTH-1:0] window_next;

    yin_sample_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (N)
    ) u_shiftreg (
        .clk         (clk),
        .reset       (reset),
        .shift_en    (sample_valid),
        .sample_in   (sample_in),
        .window_next (window_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        count_next = count;
        snap       = 1'b0;
        if (sample_valid) begin
            unique case (state)
                FILL: begin
                    if (count == CW'(N - 1)) begin
                        snap       = 1'b1;
                        count_next = '0;
                        state_next = STREAM;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
                STREAM: begin
                    if (count == CW'(HOP - 1)) begin
                        snap       = 1'b1;
                        count_next = '0;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // An unacknowledged frame is never overwritten; the new snapshot is
    // discarded and counted instead, keeping the hop cadence intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame          <= '0;
            frame_valid    <= 1'b0;
            frames_dropped <= '0;
        end else if (snap) begin
            if (!frame_valid || frame_ack) begin
                frame       <= window_next;
                frame_valid <= 1'b1;
            end else if (frames_dropped != 8'hFF) begin
                frames_dropped <= frames_dropped + 8'd1;
            end
        end else if (frame_ack) begin
            frame_valid <= 1'b0;
        end
    end

    assign filling = (state == FILL);

endmodule

// File: tb/tb_yin_window_buffer.sv
// Scoreboard bench for yin_window_buffer: randomized and directed stimulus
// against a sample-history reference model; a second instance covers HOP = 1.
module tb_yin_window_buffer;
    import yin_window_buffer_pkg::*;

    localparam int DW  = 8;
    localparam int WSB = 2;
    localparam int TAU = 2;
    localparam int HOP = 3;
    localparam int N   = calc_n(WSB, TAU);
    localparam int FW  = N * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          frame_ack = 1'b0;
    logic [FW-1:0] frame;
    logic          frame_valid;
    logic [7:0]    frames_dropped;
    logic          filling;

    logic [DW-1:0] s2_in = '0;
    logic          s2_valid = 1'b0;
    logic          s2_ack = 1'b0;
    logic [FW-1:0] f2;
    logic          fv2;
    logic [7:0]    fd2;
    logic          fill2;

    always #5 clk = ~clk;

    yin_window_buffer #(
        .DATA_WIDTH (DW), .WINDOW_SIZE_BITS (WSB), .MAX_TAU (TAU), .HOP (HOP)
    ) dut (
        .clk (clk), .reset (reset), .sample_in (sample_in), .sample_valid (sample_valid),
        .frame (frame), .frame_valid (frame_valid), .frame_ack (frame_ack),
        .frames_dropped (frames_dropped), .filling (filling)
    );

    yin_window_buffer #(
        .DATA_WIDTH (DW), .WINDOW_SIZE_BITS (WSB), .MAX_TAU (TAU), .HOP (1)
    ) dut_hop1 (
        .clk (clk), .reset (reset), .sample_in (s2_in), .sample_valid (s2_valid),
        .frame (f2), .frame_valid (fv2), .frame_ack (s2_ack),
        .frames_dropped (fd2), .filling (fill2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] pack_seq(input int start);
        logic [FW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[slot_lsb(k, DW) +: DW] = DW'(start + k);
        return r;
    endfunction

    // Reference model: full accepted-sample history; a snapshot falls on
    // sample number N, N+HOP, N+2*HOP, ...
    logic [DW-1:0] hist[$];
    logic [FW-1:0] exp_q[$];
    int            acc;
    logic [FW-1:0] m_frame, p_frame;
    logic          m_valid, p_valid;
    int            m_drop, p_drop;
    logic          m_filling, p_filling;
    logic          mon_en = 1'b0;

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        acc = 0;
        m_frame = '0;   p_frame = '0;
        m_valid = 1'b0; p_valid = 1'b0;
        m_drop = 0;     p_drop = 0;
        m_filling = 1'b1; p_filling = 1'b1;
    endtask

    task automatic model_edge(input logic v, input logic [DW-1:0] d, input logic a);
        logic          snap;
        logic [FW-1:0] w;
        p_frame = m_frame;
        p_valid = m_valid;
        p_drop  = m_drop;
        snap    = 1'b0;
        w       = '0;
        if (a && m_valid) exp_q.push_back(m_frame);
        if (v) begin
            hist.push_back(d);
            if (hist.size() > N) void'(hist.pop_front());
            acc++;
            snap = (acc >= N) && (((acc - N) % HOP) == 0);
        end
        if (snap) begin
            for (int k = 0; k < N; k++) w[slot_lsb(k, DW) +: DW] = hist[hist.size() - N + k];
            if (!m_valid || a) begin
                p_frame = w;
                p_valid = 1'b1;
            end else begin
                p_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end
        end else if (a) begin
            p_valid = 1'b0;
        end
        p_filling = (acc < N);
    endtask

    // Driver: called at posedge+1; drives inputs for the next edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic a);
        sample_valid = v;
        sample_in    = d;
        frame_ack    = a;
        model_edge(v, d, a);
        @(posedge clk);
        #1;
        m_frame = p_frame;
        m_valid = p_valid;
        m_drop  = p_drop;
        m_filling = p_filling;
        sample_valid = 1'b0;
        frame_ack    = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check({tag, "_frame"}, 64'(frame), 64'(0));
        check({tag, "_valid"}, 64'(frame_valid), 64'(0));
        check({tag, "_dropped"}, 64'(frames_dropped), 64'(0));
        check({tag, "_filling"}, 64'(filling), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: status against the model each cycle; on a transfer, pop the
    // expected frame and compare.
    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_valid", 64'(frame_valid), 64'(m_valid));
            check("mon_filling", 64'(filling), 64'(m_filling));
            check("mon_dropped", 64'(frames_dropped), 64'(m_drop));
            if (m_valid) check("mon_frame_hold", 64'(frame), 64'(m_frame));
            if (frame_valid && frame_ack) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_transfer", 64'(1), 64'(0));
                end else begin
                    check("sb_frame", 64'(frame), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        #2;
        reset = 1'b1;
        #1;
        check("reset_frame", 64'(frame), 64'(0));
        check("reset_valid", 64'(frame_valid), 64'(0));
        check("reset_dropped", 64'(frames_dropped), 64'(0));
        check("reset_filling", 64'(filling), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // First fill
        for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b0);
        check("fill_no_early_valid", 64'(frame_valid), 64'(0));
        step(1'b1, 8'd6, 1'b0);
        check("fill_valid", 64'(frame_valid), 64'(1));
        check("fill_filling", 64'(filling), 64'(0));
        check("fill_frame", 64'(frame), 64'(pack_seq(1)));

        // Hop with idle gaps
        step(1'b0, 8'd0, 1'b1);
        step(1'b1, 8'd7, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        step(1'b1, 8'd8, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        check("hop_no_early_valid", 64'(frame_valid), 64'(0));
        step(1'b1, 8'd9, 1'b0);
        check("hop_valid", 64'(frame_valid), 64'(1));
        check("hop_frame", 64'(frame), 64'(pack_seq(4)));

        // Overrun
        for (int i = 10; i <= 12; i++) step(1'b1, DW'(i), 1'b0);
        check("ovr_frame", 64'(frame), 64'(pack_seq(4)));
        check("ovr_valid", 64'(frame_valid), 64'(1));
        check("ovr_dropped", 64'(frames_dropped), 64'(1));
        step(1'b0, 8'd0, 1'b1);
        for (int i = 13; i <= 15; i++) step(1'b1, DW'(i), 1'b0);
        check("after_ovr_frame", 64'(frame), 64'(pack_seq(10)));

        // Ack coincident with a snapshot
        step(1'b1, 8'd16, 1'b0);
        step(1'b1, 8'd17, 1'b0);
        step(1'b1, 8'd18, 1'b1);
        check("coinc_frame", 64'(frame), 64'(pack_seq(13)));
        check("coinc_valid", 64'(frame_valid), 64'(1));
        check("coinc_dropped", 64'(frames_dropped), 64'(1));

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) == 0);
        end

        // Async reset mid-fill
        async_reset_check("rst_a");
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0);
        async_reset_check("rst_b");
        for (int i = 20; i <= 24; i++) step(1'b1, DW'(i), 1'b0);
        check("refill_no_early_valid", 64'(frame_valid), 64'(0));
        step(1'b1, 8'd25, 1'b0);
        check("refill_frame", 64'(frame), 64'(pack_seq(20)));
        check("refill_valid", 64'(frame_valid), 64'(1));
        check("sb_drained", 64'(exp_q.size()), 64'(0));

        // Saturation at HOP = 1: 6 fill samples, then 300 overruns
        for (int i = 1; i <= N + 300; i++) begin
            s2_valid = 1'b1;
            s2_in    = DW'(i);
            @(posedge clk);
            #1;
            if (i == N + 100) check("sat_mid_dropped", 64'(fd2), 64'(100));
        end
        s2_valid = 1'b0;
        check("sat_dropped", 64'(fd2), 64'(255));
        check("sat_valid", 64'(fv2), 64'(1));
        check("sat_frame_kept", 64'(f2), 64'(pack_seq(1)));

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
